video_timing_gen: RTL and testbench

Video timing transmitter: generates `hs_o`/`vs_o`/`de_o` plus pixel and block coordinates from free-running horizontal and vertical counters. It is the source-side counterpart of the input cursor logic. It drives HDMI output timing when no upstream source is present (hot-plug absent, bench, self-test). Its block cursor outputs use the same tile geometry (`KH`×`KV`) as the block statistics path, so it can feed the smoother directly.

---
 rtl/video_timing_gen.sv | 192 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Free-running video timing generator: HS/VS/DE, pixel and tile cursors, registered outputs.
// Optional block-checkerboard test pattern on data_o when VIDEO_TIMING_GEN_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter int KH       = 30,
    parameter int KV       = 30,
    parameter int HBLKS    = (H_WIDTH + KH - 1) / KH,
    parameter int VBLKS    = (V_HEIGHT + KV - 1) / KV
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    output logic                         busy_o,
    output logic                         hs_o,
    output logic                         vs_o,
    output logic                         de_o,
    output logic [$clog2(H_WIDTH)-1:0]   x_o,
    output logic [$clog2(V_HEIGHT)-1:0]  y_o,
    output logic [$clog2(HBLKS)-1:0]     ht_cur_o,
    output logic [$clog2(VBLKS)-1:0]     vt_cur_o,
    output logic                         sof_o,
    output logic [23:0]                  data_o
);

    // state  | meaning
    // S_IDLE | counters parked at (0,0), all outputs low
    // S_RUN  | counters advance every clock; leaves only at frame wrap with en_i low
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int HCW = $clog2(H_TOTAL);
    localparam int VCW = $clog2(V_TOTAL);
    localparam int XW  = $clog2(H_WIDTH);
    localparam int YW  = $clog2(V_HEIGHT);
    localparam int HTW = $clog2(HBLKS);
    localparam int VTW = $clog2(VBLKS);
    localparam int HBW = (KH > 1) ? $clog2(KH) : 1;
    localparam int VBW = (KV > 1) ? $clog2(KV) : 1;

    localparam logic [HBW-1:0] HB_LAST = HBW'(KH - 1);
    localparam logic [VBW-1:0] VB_LAST = VBW'(KV - 1);
    localparam logic [HTW-1:0] HT_LAST = HTW'(HBLKS - 1);
    localparam logic [VTW-1:0] VT_LAST = VTW'(VBLKS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HCW-1:0]  r_hc;
    logic [VCW-1:0]  r_vc;
    logic [HBW-1:0]  r_hb;
    logic [VBW-1:0]  r_vb;
    logic [HTW-1:0]  r_ht;
    logic [VTW-1:0]  r_vt;

    logic            r_hs, r_vs, r_de, r_sof;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [HTW-1:0]  r_ht_cur;
    logic [VTW-1:0]  r_vt_cur;

    int              w_hc;
    int              w_vc;
    logic            w_run, w_h_last, w_v_last, w_frame_wrap;
    logic            w_h_act, w_v_act, w_de, w_hs, w_vs, w_sof;

    assign w_hc         = int'(r_hc);
    assign w_vc         = int'(r_vc);
    assign w_run        = (r_state == S_RUN);
    assign w_h_last     = (w_hc == H_TOTAL - 1);
    assign w_v_last     = (w_vc == V_TOTAL - 1);
    assign w_frame_wrap = w_h_last && w_v_last;
    assign w_h_act      = (w_hc < H_WIDTH);
    assign w_v_act      = (w_vc < V_HEIGHT);
    assign w_de         = w_h_act && w_v_act;
    assign w_hs         = (w_hc >= H_START) && (w_hc < H_START + H_SYNC);
    assign w_vs         = (w_vc >= V_START) && (w_vc < V_START + V_SYNC);
    assign w_sof        = (w_hc == 0) && (w_vc == 0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_frame_wrap && !en_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tile cursor from sub-counters; indices saturate so a partial last tile keeps the last index.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !w_run) begin
            r_hc <= '0;
            r_vc <= '0;
            r_hb <= '0;
            r_ht <= '0;
            r_vb <= '0;
            r_vt <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_hb <= '0;
            r_ht <= '0;
            if (w_v_last) begin
                r_vc <= '0;
                r_vb <= '0;
                r_vt <= '0;
            end else begin
                r_vc <= r_vc + VCW'(1);
                if (w_v_act) begin
                    if (r_vb == VB_LAST) begin
                        r_vb <= '0;
                        if (r_vt != VT_LAST) r_vt <= r_vt + VTW'(1);
                    end else begin
                        r_vb <= r_vb + VBW'(1);
                    end
                end
            end
        end else begin
            r_hc <= r_hc + HCW'(1);
            if (w_h_act) begin
                if (r_hb == HB_LAST) begin
                    r_hb <= '0;
                    if (r_ht != HT_LAST) r_ht <= r_ht + HTW'(1);
                end else begin
                    r_hb <= r_hb + HBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !w_run) begin
            r_de     <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_sof    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_ht_cur <= '0;
            r_vt_cur <= '0;
        end else begin
            r_de     <= w_de;
            r_hs     <= w_hs;
            r_vs     <= w_vs;
            r_sof    <= w_sof;
            r_ht_cur <= r_ht;
            r_vt_cur <= r_vt;
            if (w_de) begin
                r_x <= r_hc[XW-1:0];
                r_y <= r_vc[YW-1:0];
            end
        end
    end

    assign busy_o   = w_run;
    assign hs_o     = r_hs;
    assign vs_o     = r_vs;
    assign de_o     = r_de;
    assign sof_o    = r_sof;
    assign x_o      = r_x;
    assign y_o      = r_y;
    assign ht_cur_o = r_ht_cur;
    assign vt_cur_o = r_vt_cur;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0] r_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !w_run || !w_de) begin
            r_data <= 24'h000000;
        end else begin
            r_data <= (r_ht[0] ^ r_vt[0]) ? 24'hFFFFFF : 24'h000000;
        end
    end

    assign data_o = r_data;
`else
    assign data_o = 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with small geometry (12x6 total, 8x4 active, 3x2 tiles).
// Reference model tracks a single frame position and decodes it arithmetically.
module tb_video_timing_gen;

    localparam int H_WIDTH  = 8;
    localparam int H_START  = 10;
    localparam int H_SYNC   = 2;
    localparam int H_TOTAL  = 12;
    localparam int V_HEIGHT = 4;
    localparam int V_START  = 5;
    localparam int V_SYNC   = 1;
    localparam int V_TOTAL  = 6;
    localparam int KH       = 3;
    localparam int KV       = 2;
    localparam int HBLKS    = (H_WIDTH + KH - 1) / KH;
    localparam int VBLKS    = (V_HEIGHT + KV - 1) / KV;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int XW       = $clog2(H_WIDTH);
    localparam int YW       = $clog2(V_HEIGHT);
    localparam int HTW      = $clog2(HBLKS);
    localparam int VTW      = $clog2(VBLKS);

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            en_i = 1'b0;
    logic            busy_o, hs_o, vs_o, de_o, sof_o;
    logic [XW-1:0]   x_o;
    logic [YW-1:0]   y_o;
    logic [HTW-1:0]  ht_cur_o;
    logic [VTW-1:0]  vt_cur_o;
    logic [23:0]     data_o;

    video_timing_gen #(
        .H_WIDTH(H_WIDTH), .H_START(H_START), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_HEIGHT(V_HEIGHT), .V_START(V_START), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
        .KH(KH), .KV(KV)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .busy_o(busy_o),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .x_o(x_o), .y_o(y_o),
        .ht_cur_o(ht_cur_o), .vt_cur_o(vt_cur_o), .sof_o(sof_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    int              m_pos = 0;
    logic            m_busy = 1'b0;
    logic            e_busy, e_de, e_hs, e_vs, e_sof;
    logic [XW-1:0]   e_x;
    logic [YW-1:0]   e_y;
    logic [HTW-1:0]  e_ht;
    logic [VTW-1:0]  e_vt;
    logic [23:0]     e_data;

    int ht_seq [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    int vt_seq [4] = '{0, 0, 1, 1};
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0] pat_line0 [8] = '{24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF,
                                   24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
`endif

    function automatic void clr_exp();
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_sof = 1'b0;
        e_x = '0; e_y = '0; e_ht = '0; e_vt = '0; e_data = '0;
    endfunction

    // Drive one edge and advance the reference model; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic en, input logic rst_n);
        int hc, vc, bh, bv;
        en_i = en;
        rst_ni = rst_n;
        @(posedge clk_i);
        hc = m_pos % H_TOTAL;
        vc = m_pos / H_TOTAL;
        if (!rst_n) begin
            clr_exp();
            m_busy = 1'b0;
            m_pos = 0;
        end else if (m_busy) begin
            bh = (hc / KH < HBLKS - 1) ? hc / KH : HBLKS - 1;
            bv = (vc / KV < VBLKS - 1) ? vc / KV : VBLKS - 1;
            e_de  = (hc < H_WIDTH) && (vc < V_HEIGHT);
            e_hs  = (hc >= H_START) && (hc < H_START + H_SYNC);
            e_vs  = (vc >= V_START) && (vc < V_START + V_SYNC);
            e_sof = (m_pos == 0);
            e_ht  = HTW'(bh);
            e_vt  = VTW'(bv);
            if (e_de) begin
                e_x = XW'(hc);
                e_y = YW'(vc);
            end
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            e_data = (e_de && (((bh ^ bv) & 1) == 1)) ? 24'hFFFFFF : 24'h000000;
`else
            e_data = 24'h000000;
`endif
            if (m_pos == FRAME - 1 && !en) begin
                m_busy = 1'b0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
        end else begin
            clr_exp();
            m_busy = en;
        end
        e_busy = m_busy;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0);
            n_cmp++;
            if ({busy_o, de_o, hs_o, vs_o, sof_o} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_ctl i=%0d got %b want 00000", i, {busy_o, de_o, hs_o, vs_o, sof_o});
            end
            n_cmp++;
            if ({x_o, y_o, ht_cur_o, vt_cur_o, data_o} !== '0) begin
                n_err++;
                $display("FAIL reset_data i=%0d got x=%0d y=%0d ht=%0d vt=%0d d=%h want all 0",
                         i, x_o, y_o, ht_cur_o, vt_cur_o, data_o);
            end
        end
    endtask

    task automatic test_frame();
        int n_de = 0, n_vs = 0, n_sof = 0, last_sof = -1, line_start = 0, hs_rise = 0;
        logic ls_ok = 1'b0, prev_hs = 1'b0, prev_de = 1'b0, prev_vs = 1'b0;
        tick(1'b1, 1'b1);
        n_cmp++;
        if ({busy_o, de_o} !== 2'b10) begin
            n_err++;
            $display("FAIL start_edge got busy/de=%b want 10", {busy_o, de_o});
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            int p, hc, vc;
            tick(1'b1, 1'b1);
            p = k % FRAME;
            hc = p % H_TOTAL;
            vc = p / H_TOTAL;
            if (k == 0) begin
                n_cmp++;
                if ({de_o, sof_o, x_o, y_o, ht_cur_o, vt_cur_o} !== {2'b11, XW'(0), YW'(0), HTW'(0), VTW'(0)}) begin
                    n_err++;
                    $display("FAIL first_pixel got de=%b sof=%b x=%0d y=%0d ht=%0d vt=%0d want 1 1 0 0 0 0",
                             de_o, sof_o, x_o, y_o, ht_cur_o, vt_cur_o);
                end
            end
            n_cmp++;
            if ({busy_o, de_o, hs_o, vs_o, sof_o} !== {e_busy, e_de, e_hs, e_vs, e_sof}) begin
                n_err++;
                $display("FAIL frame_ctl k=%0d got %b want %b", k,
                         {busy_o, de_o, hs_o, vs_o, sof_o}, {e_busy, e_de, e_hs, e_vs, e_sof});
            end
            n_cmp++;
            if ({x_o, y_o, ht_cur_o, vt_cur_o} !== {e_x, e_y, e_ht, e_vt}) begin
                n_err++;
                $display("FAIL frame_cur k=%0d got x=%0d y=%0d ht=%0d vt=%0d want %0d %0d %0d %0d",
                         k, x_o, y_o, ht_cur_o, vt_cur_o, e_x, e_y, e_ht, e_vt);
            end
            if (de_o) begin
                n_cmp++;
                if ({ht_cur_o, vt_cur_o} !== {HTW'(ht_seq[hc]), VTW'(vt_seq[vc])}) begin
                    n_err++;
                    $display("FAIL block_seq k=%0d got ht=%0d vt=%0d want %0d %0d",
                             k, ht_cur_o, vt_cur_o, ht_seq[hc], vt_seq[vc]);
                end
            end
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            if ((vc == 0 || vc == 2) && hc < H_WIDTH) begin
                n_cmp++;
                if (data_o !== ((vc == 0) ? pat_line0[hc] : ~pat_line0[hc])) begin
                    n_err++;
                    $display("FAIL pattern k=%0d line=%0d col=%0d got %h want %h", k, vc, hc, data_o,
                             (vc == 0) ? pat_line0[hc] : ~pat_line0[hc]);
                end
            end
`else
            n_cmp++;
            if (data_o !== 24'h000000) begin
                n_err++;
                $display("FAIL data_zero k=%0d got %h want 000000", k, data_o);
            end
`endif
            if (de_o) n_de++;
            if (vs_o) n_vs++;
            if (de_o && !prev_de) begin
                line_start = k;
                ls_ok = 1'b1;
            end
            if (hs_o && !prev_hs) begin
                hs_rise = k;
                if (ls_ok) begin
                    n_cmp++;
                    if (k - line_start !== H_START) begin
                        n_err++;
                        $display("FAIL hs_offset k=%0d got %0d want %0d", k, k - line_start, H_START);
                    end
                    ls_ok = 1'b0;
                end
            end
            if (!hs_o && prev_hs) begin
                n_cmp++;
                if (k - hs_rise !== H_SYNC) begin
                    n_err++;
                    $display("FAIL hs_width k=%0d got %0d want %0d", k, k - hs_rise, H_SYNC);
                end
            end
            if (vs_o && !prev_vs) begin
                n_cmp++;
                if (p !== V_START * H_TOTAL) begin
                    n_err++;
                    $display("FAIL vs_start got pos %0d want %0d", p, V_START * H_TOTAL);
                end
            end
            if (sof_o) begin
                n_sof++;
                if (last_sof >= 0) begin
                    n_cmp++;
                    if (k - last_sof !== FRAME) begin
                        n_err++;
                        $display("FAIL sof_period got %0d want %0d", k - last_sof, FRAME);
                    end
                end
                last_sof = k;
            end
            prev_de = de_o;
            prev_hs = hs_o;
            prev_vs = vs_o;
        end
        n_cmp++;
        if (n_de !== 2 * H_WIDTH * V_HEIGHT) begin
            n_err++;
            $display("FAIL de_count got %0d want %0d", n_de, 2 * H_WIDTH * V_HEIGHT);
        end
        n_cmp++;
        if (n_vs !== 2 * V_SYNC * H_TOTAL) begin
            n_err++;
            $display("FAIL vs_count got %0d want %0d", n_vs, 2 * V_SYNC * H_TOTAL);
        end
        n_cmp++;
        if (n_sof !== 2) begin
            n_err++;
            $display("FAIL sof_count got %0d want 2", n_sof);
        end
    endtask

    task automatic test_en_drop();
        int n_sof = 0;
        for (int k = 0; k < FRAME + 4; k++) begin
            tick(k < 30, 1'b1);
            if (sof_o) n_sof++;
            n_cmp++;
            if ({busy_o, de_o, hs_o, vs_o, sof_o} !== {e_busy, e_de, e_hs, e_vs, e_sof}) begin
                n_err++;
                $display("FAIL drop_ctl k=%0d got %b want %b", k,
                         {busy_o, de_o, hs_o, vs_o, sof_o}, {e_busy, e_de, e_hs, e_vs, e_sof});
            end
            if (k == FRAME - 2 || k == FRAME - 1) begin
                n_cmp++;
                if (busy_o !== (k == FRAME - 2)) begin
                    n_err++;
                    $display("FAIL drop_busy k=%0d got %b want %b", k, busy_o, k == FRAME - 2);
                end
            end
            if (k >= FRAME) begin
                n_cmp++;
                if ({busy_o, de_o, hs_o, vs_o, sof_o, x_o, y_o, ht_cur_o, vt_cur_o, data_o} !== '0) begin
                    n_err++;
                    $display("FAIL drop_idle k=%0d got ctl=%b x=%0d y=%0d ht=%0d vt=%0d d=%h want all 0", k,
                             {busy_o, de_o, hs_o, vs_o, sof_o}, x_o, y_o, ht_cur_o, vt_cur_o, data_o);
                end
            end
        end
        n_cmp++;
        if (n_sof !== 1) begin
            n_err++;
            $display("FAIL drop_sof_count got %0d want 1", n_sof);
        end
        tick(1'b1, 1'b1);
        n_cmp++;
        if ({busy_o, sof_o} !== 2'b10) begin
            n_err++;
            $display("FAIL restart_edge got busy/sof=%b want 10", {busy_o, sof_o});
        end
        tick(1'b1, 1'b1);
        n_cmp++;
        if ({sof_o, de_o} !== 2'b11) begin
            n_err++;
            $display("FAIL restart_sof got sof/de=%b want 11", {sof_o, de_o});
        end
    endtask

    task automatic test_reset_mid();
        int target, guard;
        target = int'($urandom_range(0, V_HEIGHT - 1)) * H_TOTAL + 4;
        guard = 0;
        while (!(m_busy && m_pos == target) && guard < 2 * FRAME) begin
            tick(1'b1, 1'b1);
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_err++;
            $display("FAIL midrst_reach got timeout want pos %0d", target);
        end
        n_cmp++;
        if (de_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre_de got %b want 1", de_o);
        end
        tick(1'b1, 1'b0);
        n_cmp++;
        if ({busy_o, de_o, hs_o, vs_o, sof_o, x_o, y_o, ht_cur_o, vt_cur_o, data_o} !== '0) begin
            n_err++;
            $display("FAIL midrst_zero got ctl=%b x=%0d y=%0d ht=%0d vt=%0d d=%h want all 0",
                     {busy_o, de_o, hs_o, vs_o, sof_o}, x_o, y_o, ht_cur_o, vt_cur_o, data_o);
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        n_cmp++;
        if ({de_o, sof_o, x_o, y_o} !== {2'b11, XW'(0), YW'(0)}) begin
            n_err++;
            $display("FAIL midrst_first got de=%b sof=%b x=%0d y=%0d want 1 1 0 0", de_o, sof_o, x_o, y_o);
        end
    endtask

    task automatic test_random();
        logic en_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) en_r = ~en_r;
            tick(en_r, $urandom_range(0, 499) != 0);
            n_cmp++;
            if ({busy_o, de_o, hs_o, vs_o, sof_o} !== {e_busy, e_de, e_hs, e_vs, e_sof}) begin
                n_err++;
                $display("FAIL rand_ctl k=%0d got %b want %b", k,
                         {busy_o, de_o, hs_o, vs_o, sof_o}, {e_busy, e_de, e_hs, e_vs, e_sof});
            end
            n_cmp++;
            if ({x_o, y_o, ht_cur_o, vt_cur_o} !== {e_x, e_y, e_ht, e_vt}) begin
                n_err++;
                $display("FAIL rand_cur k=%0d got x=%0d y=%0d ht=%0d vt=%0d want %0d %0d %0d %0d",
                         k, x_o, y_o, ht_cur_o, vt_cur_o, e_x, e_y, e_ht, e_vt);
            end
            n_cmp++;
            if (data_o !== e_data) begin
                n_err++;
                $display("FAIL rand_data k=%0d got %h want %h", k, data_o, e_data);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
